// File: rtl/seg_pkg.sv
// Shared segment definitions for the 7-segment display path.
// Segment vectors are active-low and ordered {CA,CB,CC,CD,CE,CF,CG,DP}.
// Bit 0 (DP) = 1 means the decimal point is off.
package seg_pkg;

    typedef logic [7:0] seg_t;

    // Bit positions within a segment vector
    localparam int SEG_CA = 7;
    localparam int SEG_CB = 6;
    localparam int SEG_CC = 5;
    localparam int SEG_CD = 4;
    localparam int SEG_CE = 3;
    localparam int SEG_CF = 2;
    localparam int SEG_CG = 1;
    localparam int SEG_DP = 0;

    // Hex glyphs, DP off
    localparam seg_t SEG_0 = 8'h03;
    localparam seg_t SEG_1 = 8'h9F;
    localparam seg_t SEG_2 = 8'h25;
    localparam seg_t SEG_3 = 8'h0D;
    localparam seg_t SEG_4 = 8'h99;
    localparam seg_t SEG_5 = 8'h49;
    localparam seg_t SEG_6 = 8'h41;
    localparam seg_t SEG_7 = 8'h1F;
    localparam seg_t SEG_8 = 8'h01;
    localparam seg_t SEG_9 = 8'h09;
    localparam seg_t SEG_A = 8'h11;
    localparam seg_t SEG_B = 8'hC1;
    localparam seg_t SEG_C = 8'h63;
    localparam seg_t SEG_D = 8'h85;
    localparam seg_t SEG_E = 8'h61;
    localparam seg_t SEG_F = 8'h71;

    localparam seg_t SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display update handshake between the system datapath and the scan controller.
//   upd_valid  : new display contents offered (master)
//   upd_ready  : controller can accept an update this cycle (slave)
//   upd_digits : hex nibbles, digit i = [4i+3:4i], digit 0 = rightmost
//   upd_dp     : decimal point enable per digit, 1 = lit
//   upd_en     : digit enable, 0 = digit blank
interface seven_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 8
);

    logic                    upd_valid;
    logic                    upd_ready;
    logic [4*NUM_DIGITS-1:0] upd_digits;
    logic [NUM_DIGITS-1:0]   upd_dp;
    logic [NUM_DIGITS-1:0]   upd_en;

    modport master (
        output upd_valid,
        output upd_digits,
        output upd_dp,
        output upd_en,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_digits,
        input  upd_dp,
        input  upd_en,
        output upd_ready
    );

endinterface

// File: rtl/seven_seg.sv
// Hex-to-7-segment decoder, purely combinational.
//   hex : 4-bit value 0..F
//   seg : active-low {CA..CG,DP}, DP always off (bit 0 = 1)
module seven_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One shared decoder; an active-low one-hot anode walks the digits with a
// blanking gap at the start of every slot. Updates land in a pending buffer
// and are committed to the displayed contents only at the frame end.
//   clk, rst   : clock, asynchronous active-high reset
//   upd        : update handshake (slave side)
//   an         : anodes, active-low, one-hot-low or all high
//   seg        : segments, active-low {CA..CG,DP}
//   frame_done : one-cycle pulse on the last tick of the last digit slot
module seven_seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000,
    parameter int unsigned CNT_W           = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    seven_seg_scan_if.slave       upd,
    output logic [NUM_DIGITS-1:0] an,
    output seg_t                  seg,
    output logic                  frame_done
);

    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] TICK_LIT  = CNT_W'(BLANK_TICKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] tick_q;
    logic [IDX_W-1:0] idx_q;

    logic                    pending_q;
    logic [4*NUM_DIGITS-1:0] pend_digits_q, act_digits_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q;
    logic [NUM_DIGITS-1:0]   pend_en_q, act_en_q;

    logic                  slot_end, frame_end, accept, dark;
    logic [3:0]            cur_digit;
    seg_t                  dec_seg;
    logic [NUM_DIGITS-1:0] an_d;
    seg_t                  seg_d;

    assign slot_end  = (tick_q == TICK_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);

    // Ready only depends on the pending flag, so a commit cycle (pending = 1)
    // can never also accept: no same-cycle accept-and-commit.
    assign upd.upd_ready = !pending_q;
    assign accept        = upd.upd_valid && !pending_q;
    assign frame_done    = frame_end;

    // Slot tick counter and digit index; index wrap is explicit so
    // NUM_DIGITS need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= '0;
            idx_q  <= '0;
        end else if (slot_end) begin
            tick_q <= '0;
            idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

    // Pending buffer and frame-boundary commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q     <= 1'b0;
            pend_digits_q <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            act_digits_q  <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
        end else if (frame_end && pending_q) begin
            act_digits_q <= pend_digits_q;
            act_dp_q     <= pend_dp_q;
            act_en_q     <= pend_en_q;
            pending_q    <= 1'b0;
        end else if (accept) begin
            pend_digits_q <= upd.upd_digits;
            pend_dp_q     <= upd.upd_dp;
            pend_en_q     <= upd.upd_en;
            pending_q     <= 1'b1;
        end
    end

    assign cur_digit = act_digits_q[{idx_q, 2'b00} +: 4];

    seven_seg u_dec (
        .hex (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        dark = (tick_q < TICK_LIT) || !act_en_q[idx_q];
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (!dark) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = {dec_seg[7:1], dec_seg[SEG_DP] & ~act_dp_q[idx_q]};
        end
    end

    // Registered pin drivers: glitch-free, one cycle behind tick/idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_d;
            seg <= seg_d;
        end
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
Time-multiplexed scan controller for the board's common-anode 7-segment display. It shares a single hex-to-segment decoder across NUM_DIGITS digits and walks an active-low anode one-hot at a fixed refresh rate. It includes a blanking gap against ghosting and an update handshake that swaps display contents only at frame boundaries, so there is no tearing. It sits between the system datapath (e.g. compare/result registers) and the top-level AN/CA..CG/DP pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned (1..8)
TICKS_PER_DIGIT, 100000, clk cycles per digit slot (1 ms at 100 MHz); minimum 2
BLANK_TICKS, 1000, cycles at start of each slot with all anodes off; must be < TICKS_PER_DIGIT
CNT_W, 17, width of slot tick counter; must satisfy 2^CNT_W >= TICKS_PER_DIGIT

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
upd_valid  in  1  new display contents offered
upd_ready  out  1  controller can accept an update this cycle
upd_digits  in  4*NUM_DIGITS  hex nibbles; digit i = [4i+3:4i], digit 0 = rightmost
upd_dp  in  NUM_DIGITS  decimal point enable per digit, 1 = lit
upd_en  in  NUM_DIGITS  digit enable, 0 = digit blank (anode held off)
an  out  NUM_DIGITS  anodes, active-low, one-hot-low or all high
seg  out  8  segments active-low, {CA,CB,CC,CD,CE,CF,CG,DP}
frame_done  out  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (async assert, sync release):
  - an = all 1; seg = 8'hFF; upd_ready = 1; frame_done = 0.
  - Tick counter = 0, digit index = 0, pending flag = 0.
  - Active and pending digits/dp/en all 0, so the display is dark until the first update.
- Slot timing:
  - The tick counter counts 0..TICKS_PER_DIGIT-1, then wraps to 0.
  - On wrap, the digit index increments. It wraps from NUM_DIGITS-1 to 0 (no power-of-2 assumption).
- Drive rules:
  - While tick < BLANK_TICKS, or when active_en[idx] = 0: an = all 1 and seg = 8'hFF.
  - Otherwise, an[idx] = 0 and all other anode bits = 1.
  - seg[7:1] = decoder output for active_digits[idx].
  - seg[0] = decoder bit0 AND NOT active_dp[idx].
- Latency: an and seg are registered, so they change 1 clk after the counter/index state that selects them.
- Update handshake:
  - A transfer occurs when upd_valid && upd_ready. upd_digits, upd_dp and upd_en are captured into the pending registers, and the pending flag is set.
  - upd_ready = !pending.
  - upd_valid may be held; the source must keep data stable until the transfer.
- Frame commit:
  - The frame end cycle is the cycle where idx = NUM_DIGITS-1 and tick = TICKS_PER_DIGIT-1.
  - On that cycle frame_done pulses. If pending = 1, pending is copied to active and the pending flag is cleared, so upd_ready = 1 on the next cycle.
  - The new contents first appear in slot 0 of the next frame.
- Simultaneous valid and commit: upd_ready is already 0, so no accept occurs. There is no same-cycle accept-and-commit and no data loss.
- Reset mid-frame or with an update pending: everything returns to reset values and the pending update is discarded.
- Decoder table is fixed: 0..F standard hex glyphs (A, b, C, d, E, F). Bit0 = 1 means DP off.

Decomposition:
- Shared package seg_pkg:
  - Segment glyph constants SEG_0..SEG_F.
  - SEG_BLANK = 8'hFF.
  - Bit position constants for CA..CG and DP.
- One sub-module: the existing seven_seg hex decoder (4-bit in, 8-bit active-low out), instanced once and fed active_digits[idx].
- Everything else (counter, index, handshake, output registers) stays inline.

Test Plan:
Use NUM_DIGITS=4, TICKS_PER_DIGIT=4, BLANK_TICKS=1.
1. Reset then idle, no update -> an=4'b1111, seg=8'hFF every cycle; frame_done pulses every 16 clks; upd_ready=1.
2. Update digits=16'h1234, dp=0, en=4'hF; run 2 frames.
   - Next frame, slot 0: tick0 blank, then an=4'b1110 with seg=8'b10011001 ("4").
   - Slot 1: an=4'b1101 with seg=8'b00001101 ("3").
   - Slot 3: an=4'b0111 with seg=8'b10011111 ("1").
3. dp=4'b0001, digits=16'h000A -> in slot 0, seg=8'b00010000 (A with DP lit); in other slots, bit0=1.
4. en=4'b0101 -> slots 1 and 3 keep an=4'b1111, seg=8'hFF for all 4 ticks; slots 0 and 2 drive normally.
5. Handshake:
   - Accept update U1 mid-frame -> upd_ready drops next clk.
   - Hold upd_valid with U2 -> not accepted until the cycle after frame_done.
   - U1 is displayed for one full frame, then U2.
6. Assert rst in slot 2 with an update pending -> outputs return to 4'b1111/8'hFF immediately (async); after release, the display stays dark and upd_ready=1.
